cpu_ma: RTL

Memory-access stage of the Risc-V CPU pipeline: sits directly downstream of the execution stage and upstream of write-back. Issues loads and stores to the data-memory port with a request/acknowledge handshake, aligns store data and byte masks, extracts and extends load data, and stalls the upstream pipeline while a memory access is outstanding. Forwarding outputs let the hazard logic see this stage's pending write-back.

---
 rtl/cpu_ma.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_ma.sv
// cpu_ma: RISC-V memory-access stage with a request/acknowledge data-memory port.
// Optional misaligned-access trap is enabled by defining CPU_MA_MISALIGN_TRAP_EN.
package cpu_ma_pkg;
  typedef enum logic [1:0] {MA_X, MA_LOAD, MA_STORE} ma_mode_t;
  typedef enum logic [2:0] {MA_SIZE_B, MA_SIZE_H, MA_SIZE_W, MA_SIZE_BU, MA_SIZE_HU} ma_size_t;
  typedef enum logic [1:0] {WB_SRC_ALU, WB_SRC_MEM, WB_SRC_PC4, WB_SRC_CSR} wb_src_t;

  localparam logic [31:0] NOP_PC = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_IR = 32'h0000_0013;
endpackage

module cpu_ma
  import cpu_ma_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] ir_i,
  input  logic [31:0] ma_addr_i,
  input  ma_mode_t    ma_mode_i,
  input  ma_size_t    ma_size_i,
  input  logic [31:0] ma_data_i,
  input  wb_src_t     wb_src_i,
  input  logic [31:0] wb_data_i,
  input  logic        wb_valid_i,
  output logic [31:0] dmem_addr_o,
  output logic        dmem_req_o,
  output logic [31:0] dmem_write_data_o,
  output logic [3:0]  dmem_write_mask_o,
  input  logic [31:0] dmem_read_data_i,
  input  logic        dmem_ack_i,
  output logic        stall_async_o,
  output logic [4:0]  wb_addr_async_o,
  output logic [31:0] wb_data_async_o,
  output logic        wb_ready_async_o,
  output logic        wb_valid_async_o,
  output logic        empty_async_o,
  output logic [31:0] pc_o,
  output logic [31:0] ir_o,
  output logic [31:0] wb_data_o,
  output logic        wb_valid_o,
  output logic        trap_o
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_valid_q, wb_valid_d;
  logic        trap_q, trap_d;

  logic        memOp;
  logic        trapTake;
  logic        reqComb;
  logic        stallComb;
  logic [1:0]  byteOff;
  logic [31:0] storeData;
  logic [3:0]  storeMask;
  logic [31:0] shiftedData;
  logic [31:0] loadData;
  logic [31:0] fwdData;

  assign memOp = ma_mode_i != MA_X;

  // Halfword and word lane offsets are forced to natural alignment.
  always_comb begin
    byteOff = 2'b00;
    case (ma_size_i)
      MA_SIZE_B, MA_SIZE_BU: byteOff = ma_addr_i[1:0];
      MA_SIZE_H, MA_SIZE_HU: byteOff = {ma_addr_i[1], 1'b0};
      default:               byteOff = 2'b00;
    endcase
  end

`ifdef CPU_MA_MISALIGN_TRAP_EN
  logic misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (ma_size_i)
      MA_SIZE_B, MA_SIZE_BU: misaligned = 1'b0;
      MA_SIZE_H, MA_SIZE_HU: misaligned = ma_addr_i[0];
      default:               misaligned = ma_addr_i[1:0] != 2'b00;
    endcase
  end

  assign trapTake = memOp && misaligned;
`else
  assign trapTake = 1'b0;
`endif

  always_comb begin
    storeData = ma_data_i;
    storeMask = 4'b1111;
    case (ma_size_i)
      MA_SIZE_B, MA_SIZE_BU: begin
        storeData = {4{ma_data_i[7:0]}};
        storeMask = 4'b0001 << byteOff;
      end
      MA_SIZE_H, MA_SIZE_HU: begin
        storeData = {2{ma_data_i[15:0]}};
        storeMask = 4'b0011 << byteOff;
      end
      default: begin
        storeData = ma_data_i;
        storeMask = 4'b1111;
      end
    endcase
  end

  assign shiftedData = dmem_read_data_i >> {byteOff, 3'b000};

  always_comb begin
    loadData = shiftedData;
    case (ma_size_i)
      MA_SIZE_B:  loadData = {{24{shiftedData[7]}}, shiftedData[7:0]};
      MA_SIZE_BU: loadData = {24'h0, shiftedData[7:0]};
      MA_SIZE_H:  loadData = {{16{shiftedData[15]}}, shiftedData[15:0]};
      MA_SIZE_HU: loadData = {16'h0, shiftedData[15:0]};
      default:    loadData = shiftedData;
    endcase
  end

  assign fwdData = (wb_src_i == WB_SRC_MEM) ? loadData : wb_data_i;

  // Bubble by default; only a pass-through, a trap or an acknowledged access captures.
  always_comb begin
    state_d    = state_q;
    reqComb    = 1'b0;
    stallComb  = 1'b0;
    pc_d       = NOP_PC;
    ir_d       = NOP_IR;
    wb_data_d  = wb_data_q;
    wb_valid_d = 1'b0;
    trap_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trapTake) begin
          pc_d      = pc_i;
          ir_d      = ir_i;
          wb_data_d = wb_data_i;
          trap_d    = 1'b1;
        end else if (memOp) begin
          reqComb   = 1'b1;
          stallComb = 1'b1;
          state_d   = S_WAIT;
        end else begin
          pc_d       = pc_i;
          ir_d       = ir_i;
          wb_data_d  = wb_data_i;
          wb_valid_d = wb_valid_i;
        end
      end
      S_WAIT: begin
        if (dmem_ack_i) begin
          state_d    = S_IDLE;
          pc_d       = pc_i;
          ir_d       = ir_i;
          wb_data_d  = fwdData;
          wb_valid_d = wb_valid_i;
        end else begin
          stallComb = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      pc_q       <= NOP_PC;
      ir_q       <= NOP_IR;
      wb_data_q  <= 32'h0;
      wb_valid_q <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      wb_data_q  <= wb_data_d;
      wb_valid_q <= wb_valid_d;
      trap_q     <= trap_d;
    end
  end

  assign dmem_addr_o       = {ma_addr_i[31:2], 2'b00};
  assign dmem_req_o        = reqComb && !rst_i;
  assign dmem_write_data_o = storeData;
  assign dmem_write_mask_o = (ma_mode_i == MA_STORE) ? storeMask : 4'b0000;

  assign stall_async_o    = stallComb;
  assign wb_addr_async_o  = ir_i[11:7];
  assign wb_data_async_o  = fwdData;
  assign wb_ready_async_o = (wb_src_i != WB_SRC_MEM) || ((state_q == S_WAIT) && dmem_ack_i);
  assign wb_valid_async_o = wb_valid_i;
  assign empty_async_o    = pc_i == NOP_PC;

  assign pc_o       = pc_q;
  assign ir_o       = ir_q;
  assign wb_data_o  = wb_data_q;
  assign wb_valid_o = wb_valid_q;
  assign trap_o     = trap_q;

endmodule
